// File: rtl/alu_reg32_if.sv
// rtl/alu_reg32_if.sv - operand/result bundle for the registered ALU
// Purpose: groups the ALU request (i_valid, a, b, control) and the registered
// response (o_valid, result, overflow, zero, equal) into one interface.
// Ports (signals):
//   i_valid  operands/control valid this cycle
//   a, b     operands (b[4:0] is the shift amount)
//   control  4-bit operation code
//   o_valid  registered outputs belong to a valid sampled operation
//   result   operation result
//   overflow signed overflow of ADD/SUB
//   zero     result == 0
//   equal    a == b
// Modports: master drives the request, slave (the ALU) drives the response.
interface alu_reg32_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   control;
  logic         o_valid;
  logic [N-1:0] result;
  logic         overflow;
  logic         zero;
  logic         equal;

  modport master (
    output i_valid, a, b, control,
    input  o_valid, result, overflow, zero, equal
  );

  modport slave (
    input  i_valid, a, b, control,
    output o_valid, result, overflow, zero, equal
  );
endinterface

// File: rtl/alu_reg32.sv
// rtl/alu_reg32.sv - registered 32-bit integer ALU with result flags
// Purpose: one-cycle-latency ALU for an RV32I-style datapath. One shared
// adder serves ADD/SUB/SLT/SLTU; one right barrel shifter serves all three
// shifts (SLL runs through it bit-reversed).
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    alu_reg32_if.slave (i_valid, a, b, control in; o_valid, result,
//          overflow, zero, equal out)
// Build option: ALU_OVERFLOW_EN - when defined the overflow output reports
// signed ADD/SUB overflow; when undefined it is tied to 0.
module alu_reg32 #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_reg32_if.slave   bus
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_ADD  = 4'b1000,
    ALU_SUB  = 4'b1100,
    ALU_SLT  = 4'b1101,
    ALU_SLTU = 4'b1111
  } alu_control_t;

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] x);
    logic [N-1:0] y;
    for (int i = 0; i < N; i++) y[i] = x[N-1-i];
    return y;
  endfunction

  alu_control_t op;
  assign op = alu_control_t'(bus.control);

  // Shared adder: compares are subtractions, so b is inverted with carry-in 1.
  logic         sub_op;
  logic [N-1:0] b_op;
  logic [N:0]   add_full;
  logic [N-1:0] sum;
  logic         carry;
  logic         ovf_int;
  logic         lt_s;
  logic         lt_u;

  assign sub_op   = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  assign b_op     = sub_op ? ~bus.b : bus.b;
  assign add_full = {1'b0, bus.a} + {1'b0, b_op} + {{N{1'b0}}, sub_op};
  assign sum      = add_full[N-1:0];
  assign carry    = add_full[N];
  // Same-sign addends producing a different-sign sum; with b_op this covers SUB.
  assign ovf_int  = (bus.a[N-1] == b_op[N-1]) && (sum[N-1] != bus.a[N-1]);
  // Signed less-than must survive overflow, hence the XOR with ovf_int.
  assign lt_s     = sum[N-1] ^ ovf_int;
  // No carry out of a + ~b + 1 means a borrow, i.e. a < b unsigned.
  assign lt_u     = ~carry;

  // Right barrel shifter; SLL reverses the operand in and the result out.
  logic [4:0]   shamt;
  logic         fill;
  logic [N-1:0] sh0, sh1, sh2, sh3, sh4, sh5;

  assign shamt = bus.b[4:0];
  assign fill  = (op == ALU_SRA) & bus.a[N-1];
  assign sh0   = (op == ALU_SLL) ? bit_rev(bus.a) : bus.a;
  assign sh1   = shamt[0] ? {{1{fill}},  sh0[N-1:1]}  : sh0;
  assign sh2   = shamt[1] ? {{2{fill}},  sh1[N-1:2]}  : sh1;
  assign sh3   = shamt[2] ? {{4{fill}},  sh2[N-1:4]}  : sh2;
  assign sh4   = shamt[3] ? {{8{fill}},  sh3[N-1:8]}  : sh3;
  assign sh5   = shamt[4] ? {{16{fill}}, sh4[N-1:16]} : sh4;

  logic [N-1:0] result_d;
  logic         zero_d;
  logic         equal_d;

  always_comb begin
    result_d = '0;
    case (op)
      ALU_AND:  result_d = bus.a & bus.b;
      ALU_OR:   result_d = bus.a | bus.b;
      ALU_XOR:  result_d = bus.a ^ bus.b;
      ALU_SLL:  result_d = bit_rev(sh5);
      ALU_SRL:  result_d = sh5;
      ALU_SRA:  result_d = sh5;
      ALU_ADD:  result_d = sum;
      ALU_SUB:  result_d = sum;
      ALU_SLT:  result_d = {{(N-1){1'b0}}, lt_s};
      ALU_SLTU: result_d = {{(N-1){1'b0}}, lt_u};
      default:  result_d = '0;
    endcase
  end

  assign zero_d  = (result_d == '0);
  assign equal_d = (bus.a == bus.b);

  logic         o_valid_q;
  logic [N-1:0] result_q;
  logic         zero_q;
  logic         equal_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_valid_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      o_valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        result_q <= result_d;
        zero_q   <= zero_d;
        equal_q  <= equal_d;
      end
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic overflow_d;
  logic overflow_q;

  assign overflow_d = ((op == ALU_ADD) || (op == ALU_SUB)) && ovf_int;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (bus.i_valid) begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.o_valid = o_valid_q;
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.equal   = equal_q;

endmodule

// File: tb/tb_alu_reg32.sv
// tb/tb_alu_reg32.sv - scoreboard testbench for alu_reg32
module tb_alu_reg32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_reg32_if bus ();

  alu_reg32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ALU_OVERFLOW_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] r;
    logic        o;
    logic        z;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_v = 1'b0;
  logic cur_v  = 1'b0;
  bit   vchk   = 1'b0;

  // Reference model: plain arithmetic on the operation semantics.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, s;
    logic [31:0] r;
    logic        o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    o  = 1'b0;
    case (c)
      4'b0001: r = a & b;
      4'b0010: r = a | b;
      4'b0011: r = a ^ b;
      4'b0101: r = a << b[4:0];
      4'b0110: r = a >> b[4:0];
      4'b0111: r = $unsigned($signed(a) >>> b[4:0]);
      4'b1000: begin
        r = a + b;
        s = sa + sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1100: begin
        r = a - b;
        s = sa - sb;
        o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b1101: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: r = (a < b) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
`ifndef ALU_OVERFLOW_EN
    o = 1'b0;
`endif
    e.r = r;
    e.o = o;
    e.z = (r == 32'd0);
    e.e = (a == b);
    return e;
  endfunction

  task automatic drive(input logic rst, input logic v, input logic [3:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    rst_n       = rst;
    bus.i_valid = v;
    bus.control = c;
    bus.a       = a;
    bus.b       = b;
    prev_v      = cur_v;
    cur_v       = v & rst;
    vchk        = 1'b1;
  endtask

  task automatic drive_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, 1'b1, c, a, b);
    q.push_back(model(c, a, b));
  endtask

  task automatic drive_known(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] r, input logic o, input logic z, input logic e);
    exp_t x;
    drive(1'b1, 1'b1, c, a, b);
    x.r = r;
    x.o = o;
    x.z = z;
    x.e = e;
    q.push_back(x);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  // Monitor: checks o_valid every cycle and pops the scoreboard on each valid output.
  always @(negedge clk) begin
    if (vchk) begin
      n_vec++;
      if (bus.o_valid !== prev_v) begin
        n_err++;
        $display("FAIL o_valid got %b exp %b at %0t", bus.o_valid, prev_v, $time);
      end
      if (bus.o_valid === 1'b1) begin
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output result %h at %0t", bus.result, $time);
        end else begin
          exp_t x;
          x = q.pop_front();
          n_vec++;
          if ({bus.result, bus.overflow, bus.zero, bus.equal} !== {x.r, x.o, x.z, x.e}) begin
            n_err++;
            $display("FAIL output got r=%h o=%b z=%b e=%b exp r=%h o=%b z=%b e=%b at %0t",
                     bus.result, bus.overflow, bus.zero, bus.equal, x.r, x.o, x.z, x.e, $time);
          end
        end
      end
    end
  end

  logic [3:0]  ops [10] = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                            4'b0111, 4'b1000, 4'b1100, 4'b1101, 4'b1111};
  logic [3:0]  bad [6]  = '{4'b0000, 4'b0100, 4'b1001, 4'b1010, 4'b1011, 4'b1110};
  logic [31:0] corner [9] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0002,
                              32'h0000_001F, 32'h0000_0020, 32'hA5A5_A5A5};

  initial begin
    bus.i_valid = 1'b0;
    bus.control = 4'b0000;
    bus.a       = 32'd0;
    bus.b       = 32'd0;

    // Reset with a valid ADD pending: nothing may come out.
    drive(1'b0, 1'b1, 4'b1000, 32'd5, 32'd5);
    drive(1'b0, 1'b1, 4'b1000, 32'd5, 32'd5);
    @(negedge clk);
    chk("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags", {29'd0, bus.overflow, bus.zero, bus.equal}, 32'd0);
    drive_known(4'b1000, 32'd5, 32'd5, 32'h0000_000A, 1'b0, 1'b0, 1'b1);

    // Directed boundary cases with fixed expectations.
    drive_known(4'b1000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, OVF, 1'b0, 1'b0);
    drive_known(4'b1100, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, OVF, 1'b0, 1'b0);
    drive_known(4'b1100, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    drive_known(4'b1101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drive_known(4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    drive_known(4'b1101, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drive_known(4'b1101, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    drive_known(4'b0111, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    drive_known(4'b0110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drive_known(4'b0101, 32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drive_known(4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b1, 1'b1);
    drive_known(4'b0000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b1, 1'b0);

    // Latency / hold: one op, then two idles; result must hold with o_valid low.
    drive_known(4'b0010, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    @(negedge clk);
    chk("hold_result", bus.result, 32'h1234_5678);
    chk("hold_o_valid", {31'd0, bus.o_valid}, 32'd0);

    // Corner sweep over all ops, with occasional idle cycles.
    foreach (ops[k]) begin
      foreach (corner[i]) begin
        foreach (corner[j]) begin
          drive_op(ops[k], corner[i], corner[j]);
          if ($urandom_range(0, 15) == 0) idle();
        end
      end
    end

    // Random pairs per op, plus undefined codes.
    foreach (ops[k]) begin
      for (int n = 0; n < 25; n++) begin
        drive_op(ops[k], $urandom, $urandom);
        if ($urandom_range(0, 7) == 0) idle();
      end
    end
    for (int n = 0; n < 24; n++) begin
      drive_op(bad[$urandom_range(0, 5)], $urandom, $urandom);
    end

    // Mid-run reset: the op sampled on the reset edge is discarded.
    drive_op(4'b1000, 32'd3, 32'd4);
    drive(1'b0, 1'b1, 4'b1000, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    idle();
    @(negedge clk);
    chk("rst2_result", bus.result, 32'd0);
    chk("rst2_flags", {29'd0, bus.overflow, bus.zero, bus.equal}, 32'd0);
    drive_op(4'b1100, 32'd1, 32'd2);

    idle();
    idle();
    idle();
    @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
